// File: rtl/dmem_ctrl_if.sv
// Load/store handshake between the processor datapath and the data-memory controller.
// The processor is the master; the controller implements the slave side.
interface dmem_ctrl_if;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_ctrl.sv
// Data-memory controller: one load/store at a time against an internal word memory,
// with programmable wait states and a one-cycle response pulse back to write-back.
module dmem_ctrl #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic       CLK,
    input  logic       reset,
    dmem_ctrl_if.slave bus,
    output logic       busy
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP, ERR} state_t;

    state_t            state;
    state_t            state_next;
    logic [3:0]        wait_cnt;
    logic              lat_we;
    logic              lat_bad;
    logic [IDX_W-1:0]  lat_idx;
    logic [31:0]       lat_wdata;
    logic [31:0]       rdata_q;
    logic [31:0]       mem [DEPTH_WORDS];
    logic              addr_bad;
    logic              access_now;

    // Word index is compared unsigned over the full 30 bits so high addresses never alias.
    assign addr_bad   = (bus.req_addr[1:0] != 2'b00) ||
                        ({2'b00, bus.req_addr[31:2]} >= 32'(DEPTH_WORDS));
    assign access_now = (state == WAIT) && (wait_cnt == 4'd0);

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Rejected requests spend one cycle in WAIT with a zero count, so the error
    // response lands one edge after acceptance without ever touching memory.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (bus.req_valid) state_next = WAIT;
            WAIT: if (wait_cnt == 4'd0) state_next = lat_bad ? ERR : RESP;
            RESP: state_next = IDLE;
            ERR:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            wait_cnt  <= 4'd0;
            lat_we    <= 1'b0;
            lat_bad   <= 1'b0;
            lat_idx   <= '0;
            lat_wdata <= '0;
            rdata_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        lat_we    <= bus.req_we;
                        lat_bad   <= addr_bad;
                        lat_idx   <= bus.req_addr[IDX_W+1:2];
                        lat_wdata <= bus.req_wdata;
                        wait_cnt  <= addr_bad ? 4'd0 : 4'(WAIT_STATES);
                    end
                end
                WAIT: begin
                    if (wait_cnt != 4'd0) begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end else if (lat_bad) begin
                        rdata_q <= '0;
                    end else if (lat_we) begin
                        rdata_q <= lat_wdata;
                    end else begin
                        rdata_q <= mem[lat_idx];
                    end
                end
                default: ;
            endcase
        end
    end

    // Memory is deliberately outside the reset domain; contents survive reset.
    always_ff @(posedge CLK) begin
        if (access_now && !lat_bad && lat_we) begin
            mem[lat_idx] <= lat_wdata;
        end
    end

    always_comb begin
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_err   = 1'b0;
        busy           = 1'b1;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                busy          = 1'b0;
            end
            RESP: bus.resp_valid = 1'b1;
            ERR: begin
                bus.resp_valid = 1'b1;
                bus.resp_err   = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.resp_rdata = rdata_q;

endmodule
